// File: rtl/uart_autobaud_ctrl.sv
// Divisor controller for the UART 16x baud generator: software passthrough or
// auto-baud lock by timing a received 0x55 sync character on the RX line.
module uart_autobaud_ctrl #(
  parameter int unsigned DIV_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 auto_en,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] sw_divisor,
  output logic [DIV_WIDTH-1:0] divisor_out,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned CNT_WIDTH = DIV_WIDTH + 7;

  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, CHECK, FAIL} state_t;

  state_t               state, state_d;
  logic                 rx_meta, rx_s, rx_s_prev;
  logic [CNT_WIDTH-1:0] cnt, cnt_d, last, last_d, ref_int, ref_d, total, total_d;
  logic [2:0]           edges, edges_d;
  logic [DIV_WIDTH-1:0] div_d;
  logic                 busy_d, done_d, error_d;

  logic                 fall;
  logic [CNT_WIDTH-1:0] cnt_inc, interval, lo;
  logic [CNT_WIDTH:0]   hi;
  logic                 in_range;
  logic [DIV_WIDTH:0]   div_wide;

  assign fall     = rx_s_prev & ~rx_s;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign interval = cnt_inc - last;
  assign lo       = ref_int - (ref_int >> 2);
  assign hi       = {1'b0, ref_int} + {1'b0, ref_int >> 2};
  assign in_range = (interval >= lo) && ({1'b0, interval} <= hi);
  // total/128 rounded to nearest; one extra bit keeps the +64 from overflowing
  assign div_wide = (DIV_WIDTH+1)'(({1'b0, total} + (CNT_WIDTH+1)'(64)) >> 7);

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    ref_d   = ref_int;
    total_d = total;
    edges_d = edges;
    div_d   = auto_en ? divisor_out : sw_divisor;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && auto_en) state_d = ARMED;
      end
      ARMED: begin
        if (fall) begin
          cnt_d   = '0;
          last_d  = '0;
          ref_d   = '0;
          edges_d = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (cnt == '1) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_inc;
          if (fall) begin
            last_d  = cnt_inc;
            edges_d = 3'(edges + 3'd1);
            if (edges == 3'd0) begin
              ref_d = interval;
            end else if (!in_range) begin
              state_d = FAIL;
            end else if (edges == 3'd3) begin
              total_d = cnt_inc;
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (div_wide > (DIV_WIDTH+1)'(1)) begin
          div_d   = div_wide[DIV_WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FAIL;
        end
      end
      FAIL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Leaving auto mode abandons any measurement silently
    if (!auto_en && (state inside {ARMED, MEASURE, CHECK})) begin
      state_d = IDLE;
      done_d  = 1'b0;
      div_d   = sw_divisor;
    end

    error_d = (state_d == FAIL);
    busy_d  = (state_d inside {ARMED, MEASURE, CHECK});
  end

  // State, synchroniser, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_s_prev   <= 1'b1;
      cnt         <= '0;
      last        <= '0;
      ref_int     <= '0;
      total       <= '0;
      edges       <= '0;
      divisor_out <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      rx_meta     <= rx_in;
      rx_s        <= rx_meta;
      rx_s_prev   <= rx_s;
      cnt         <= cnt_d;
      last        <= last_d;
      ref_int     <= ref_d;
      total       <= total_d;
      edges       <= edges_d;
      divisor_out <= div_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

endmodule
